// File: rtl/runway_pkg.sv
// rtl/runway_pkg.sv - shared light codes, step classes and decoder states
package runway_pkg;

  localparam logic [2:0] LT_ENDS  = 3'b101;
  localparam logic [2:0] LT_MID   = 3'b010;
  localparam logic [2:0] LT_LEFT  = 3'b100;
  localparam logic [2:0] LT_RIGHT = 3'b001;

  // Low two bits of a real class are the wind code it recovers.
  typedef enum logic [2:0] {
    WIND_CALM = 3'd0,
    WIND_R2L  = 3'd1,
    WIND_L2R  = 3'd2,
    WIND_HOLD = 3'd3,
    CLS_NONE  = 3'd4
  } step_class_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } dec_state_e;

endpackage

// File: rtl/runway_step_classifier.sv
// rtl/runway_step_classifier.sv - maps a (prev, cur) light pair to a step class
module runway_step_classifier
  import runway_pkg::*;
(
  input  logic [2:0]  prev_i,
  input  logic [2:0]  cur_i,
  output step_class_e cls_o,
  output logic        illegal_o
);

  always_comb begin
    cls_o     = CLS_NONE;
    illegal_o = !((cur_i == LT_ENDS) || (cur_i == LT_MID) ||
                  (cur_i == LT_LEFT) || (cur_i == LT_RIGHT));
    if (cur_i == prev_i) begin
      cls_o = WIND_HOLD;
    end else begin
      case ({prev_i, cur_i})
        {LT_ENDS, LT_MID},
        {LT_MID, LT_ENDS}:   cls_o = WIND_CALM;
        {LT_RIGHT, LT_MID},
        {LT_MID, LT_LEFT},
        {LT_LEFT, LT_RIGHT}: cls_o = WIND_R2L;
        {LT_LEFT, LT_MID},
        {LT_MID, LT_RIGHT},
        {LT_RIGHT, LT_LEFT}: cls_o = WIND_L2R;
        default:             cls_o = CLS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/runway_pattern_decoder.sv
// rtl/runway_pattern_decoder.sv - recovers and qualifies the wind mode from the runway light bus
module runway_pattern_decoder
  import runway_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       sample_en,
  input  logic [2:0] lights,
  output logic [1:0] wind,
  output logic       locked,
  output logic       pattern_err,
  output logic       timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = TIMEOUT[WD_W-1:0];
  localparam logic [3:0]      CNT_MAX = LOCK_COUNT[3:0];

  dec_state_e      state_q, state_d;
  logic [2:0]      prev_q, prev_d;
  step_class_e     cand_q, cand_d;
  logic [3:0]      count_q, count_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [1:0]      wind_q, wind_d;
  logic            locked_q, locked_d;
  logic            err_q, err_d;
  logic            to_q, to_d;

  step_class_e cls;
  step_class_e wind_cls;
  logic        illegal;
  logic [3:0]  count_inc;

  runway_step_classifier u_classifier (
    .prev_i    (prev_q),
    .cur_i     (lights),
    .cls_o     (cls),
    .illegal_o (illegal)
  );

  assign wind_cls  = step_class_e'({1'b0, wind_q});
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cand_d   = cand_q;
    count_d  = count_q;
    wd_d     = wd_q;
    wind_d   = wind_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    to_d     = 1'b0;

    if (sample_en) begin
      wd_d = '0;
      if (illegal) begin
        err_d    = 1'b1;
        state_d  = IDLE;
        locked_d = 1'b0;
        count_d  = '0;
      end else begin
        case (state_q)
          IDLE: begin
            prev_d  = lights;
            state_d = TRACK;
            cand_d  = WIND_CALM;
            count_d = '0;
          end
          TRACK: begin
            prev_d = lights;
            if (cls == CLS_NONE) begin
              count_d = '0;
            end else if ((cls == cand_q) && (count_q != 4'd0)) begin
              count_d = count_inc;
            end else begin
              cand_d  = cls;
              count_d = 4'd1;
            end
            if ((cls != CLS_NONE) && (count_d == CNT_MAX)) begin
              state_d  = LOCKED;
              wind_d   = cand_d[1:0];
              locked_d = 1'b1;
            end
          end
          LOCKED: begin
            prev_d = lights;
            if (cls != wind_cls) begin
              locked_d = 1'b0;
              state_d  = TRACK;
              cand_d   = cls;
              count_d  = (cls == CLS_NONE) ? 4'd0 : 4'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q == IDLE) begin
      wd_d = '0;
    end else if (wd_q == WD_MAX - 1'b1) begin
      // This idle cycle is the TIMEOUT-th since the last strobe.
      to_d     = 1'b1;
      state_d  = IDLE;
      locked_d = 1'b0;
      count_d  = '0;
      wd_d     = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      prev_q   <= 3'b000;
      cand_q   <= WIND_CALM;
      count_q  <= '0;
      wd_q     <= '0;
      wind_q   <= 2'b00;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cand_q   <= cand_d;
      count_q  <= count_d;
      wd_q     <= wd_d;
      wind_q   <= wind_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  assign wind        = wind_q;
  assign locked      = locked_q;
  assign pattern_err = err_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_runway_pattern_decoder.sv
// tb/tb_runway_pattern_decoder.sv - directed and randomized checks against a rule-level model
module tb_runway_pattern_decoder;

  localparam int LC = 3;
  localparam int TO = 8;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       sample_en = 1'b0;
  logic [2:0] lights = 3'b000;
  logic [1:0] wind;
  logic       locked;
  logic       pattern_err;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  // Reference model: tracking flag, run of identical step classes, idle gap.
  int m_active, m_locked, m_wind, m_prev, m_run_cls, m_run_len, m_idle;
  int exp_err, exp_to;

  runway_pattern_decoder #(.LOCK_COUNT(LC), .TIMEOUT(TO)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .sample_en   (sample_en),
    .lights      (lights),
    .wind        (wind),
    .locked      (locked),
    .pattern_err (pattern_err),
    .timeout     (timeout)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1ms;
    $display("FAIL global_time_limit: observed running expected finished");
    $fatal(1);
  end

  function automatic int is_legal(int c);
    return (c == 5) || (c == 2) || (c == 4) || (c == 1);
  endfunction

  // Position of a single-lamp code: right=0, mid=1, left=2.
  function automatic int pos(int c);
    if (c == 1) return 0;
    if (c == 2) return 1;
    if (c == 4) return 2;
    return -1;
  endfunction

  function automatic int classify(int p, int c);
    if (p == c) return 3;
    if ((p == 5 && c == 2) || (p == 2 && c == 5)) return 0;
    if (pos(p) >= 0 && pos(c) >= 0)
      return (((pos(c) - pos(p) + 3) % 3) == 1) ? 1 : 2;
    return 4;
  endfunction

  function automatic int next_code(int mode, int last);
    int l;
    l = is_legal(last) ? last : 1;
    case (mode)
      0: return (l == 5) ? 2 : 5;
      1: return pos(l) < 0 ? 1 : ((l << 1) | (l >> 2)) & 7;
      2: return pos(l) < 0 ? 1 : ((l >> 1) | (l << 2)) & 7;
      default: return l;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_locked = 0; m_wind = 0; m_prev = 0;
    m_run_cls = 0; m_run_len = 0; m_idle = 0;
    exp_err = 0; exp_to = 0;
  endtask

  task automatic check_outputs();
    chk("wind", {30'd0, wind}, m_wind);
    chk("locked", {31'd0, locked}, m_locked);
    chk("pattern_err", {31'd0, pattern_err}, exp_err);
    chk("timeout", {31'd0, timeout}, exp_to);
  endtask

  task automatic cyc(input logic en, input logic [2:0] l);
    int c;
    int code;
    @(negedge Clock);
    sample_en = en;
    lights    = l;
    @(posedge Clock);
    #1;
    code = int'(l);
    exp_err = 0;
    exp_to  = 0;
    if (en) begin
      m_idle = 0;
      if (!is_legal(code)) begin
        exp_err = 1; m_active = 0; m_locked = 0;
      end else if (!m_active) begin
        m_active = 1; m_prev = code; m_run_len = 0;
      end else begin
        c = classify(m_prev, code);
        m_prev = code;
        if (m_locked) begin
          if (c != m_wind) begin
            m_locked = 0; m_run_cls = c; m_run_len = (c == 4) ? 0 : 1;
          end
        end else begin
          if (c == 4) m_run_len = 0;
          else if (c == m_run_cls && m_run_len > 0) m_run_len++;
          else begin m_run_cls = c; m_run_len = 1; end
          if (m_run_len >= LC) begin m_locked = 1; m_wind = m_run_cls; end
        end
      end
    end else if (m_active) begin
      m_idle++;
      if (m_idle >= TO) begin
        exp_to = 1; m_active = 0; m_locked = 0; m_idle = 0;
      end
    end
    check_outputs();
  endtask

  // Reset asserted between edges must clear outputs without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge Clock);
    sample_en = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk({tag, "_async_wind"}, {30'd0, wind}, 0);
    chk({tag, "_async_locked"}, {31'd0, locked}, 0);
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic seq4(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
    cyc(1'b1, a); cyc(1'b1, b); cyc(1'b1, c); cyc(1'b1, d);
  endtask

  initial begin
    int mode, last, code, g, r;
    int codes[4] = '{5, 2, 4, 1};
    model_reset();

    repeat (3) @(posedge Clock);
    #1;
    check_outputs();
    @(negedge Clock);
    Reset = 1'b0;

    seq4(3'b001, 3'b010, 3'b100, 3'b001);
    chk("r2l_lock", {29'd0, locked, wind}, 3'b101);
    do_reset("mid_locked");

    seq4(3'b101, 3'b010, 3'b101, 3'b010);
    chk("calm_lock", {29'd0, locked, wind}, 3'b100);

    do_reset("l2r");
    seq4(3'b100, 3'b010, 3'b001, 3'b100);
    chk("l2r_lock", {29'd0, locked, wind}, 3'b110);
    cyc(1'b1, 3'b101);
    chk("mode_change_unlock", {29'd0, locked, wind}, 3'b010);
    cyc(1'b1, 3'b010); cyc(1'b1, 3'b101); cyc(1'b1, 3'b010);
    chk("calm_relock", {29'd0, locked, wind}, 3'b100);

    do_reset("illegal");
    seq4(3'b001, 3'b010, 3'b100, 3'b001);
    cyc(1'b1, 3'b111);
    chk("illegal_err", {28'd0, pattern_err, locked, wind}, 4'b1001);
    seq4(3'b010, 3'b100, 3'b001, 3'b010);
    chk("illegal_recover", {29'd0, locked, wind}, 3'b101);

    do_reset("timeout");
    seq4(3'b001, 3'b010, 3'b100, 3'b001);
    repeat (TO) cyc(1'b0, 3'b000);
    chk("timeout_fired", {30'd0, timeout, locked}, 2'b10);
    cyc(1'b0, 3'b000);
    seq4(3'b001, 3'b010, 3'b100, 3'b001);
    repeat (TO - 1) cyc(1'b0, 3'b111);
    cyc(1'b1, 3'b010);
    chk("strobe_at_expiry", {29'd0, timeout, locked, wind}, 4'b0101);
    repeat (3) cyc(1'b0, 3'b000);

    do_reset("hold_fast");
    seq4(3'b010, 3'b010, 3'b010, 3'b010);
    chk("hold_fast", {29'd0, locked, wind}, 3'b111);
    do_reset("hold_slow");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 3'b010);
      if (i < 3) repeat (6) cyc(1'b0, 3'b000);
    end
    chk("hold_slow", {29'd0, locked, wind}, 3'b111);

    do_reset("random");
    mode = 0;
    last = 5;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) mode = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 19));
      g = (r < 12) ? 0 : (r < 18) ? int'($urandom_range(1, 3)) : int'($urandom_range(6, 10));
      repeat (g) cyc(1'b0, 3'($urandom));
      r = int'($urandom_range(0, 19));
      if (r == 0) code = int'($urandom_range(0, 7));
      else if (r < 3) code = codes[$urandom_range(0, 3)];
      else code = next_code(mode, last);
      last = code;
      cyc(1'b1, code[2:0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/runway_pattern_decoder.md
Name: runway_pattern_decoder

Overview:
Receive-side counterpart of the runway light sequencer. Watches the 3-bit runway light bus, one sample per light step. Classifies each step-to-step transition and recovers the wind mode code that produced the pattern. Reports a qualified (locked) wind code plus error and timeout pulses, for use by tower monitoring and self-check logic.

Parameters:
LOCK_COUNT, 3, consecutive same-class steps required to assert lock (range 1..15)
TIMEOUT, 64, Clock cycles without sample_en before tracking is abandoned (range 2..2^16)

Ports:
Clock  input  1  system clock, all state updates on posedge
Reset  input  1  asynchronous, active-high; clears all state immediately
sample_en  input  1  one-cycle strobe: lights holds a new step this cycle
lights  input  3  light bus, bit2 = left lamp, bit0 = right lamp
wind  output  2  recovered mode: 00 calm, 01 right-to-left, 10 left-to-right, 11 hold
locked  output  1  high while wind is qualified
pattern_err  output  1  one-cycle pulse on an illegal light code
timeout  output  1  one-cycle pulse when the TIMEOUT watchdog expires

Behaviour:
- Reset is asynchronous and active-high. Reset values: wind=00, locked=0, pattern_err=0, timeout=0, state=IDLE, prev=000, cand=00, count=0, watchdog=0.
- Legal codes: 101 (ends), 010 (mid), 100 (left), 001 (right). Codes 000, 011, 110 and 111 are illegal.
- Step class, from (prev, cur):
  - CALM: 101->010 or 010->101
  - R2L: 001->010, 010->100, 100->001
  - L2R: 100->010, 010->001, 001->100
  - HOLD: cur == prev
  - NONE: any other legal pair, e.g. 101->001 (mode change)
- All outputs are registered. Effects of a sample_en cycle are visible after that Clock edge (latency 1).
- Any sample_en with an illegal code, in any state:
  - pattern_err=1 for one cycle; state goes to IDLE; locked=0; count=0
  - wind keeps its last value
- IDLE:
  - On a legal sample: prev=cur; go to TRACK; cand=00; count=0.
- TRACK, on a legal sample:
  - Compute the class; prev=cur.
  - NONE: count=0.
  - class == cand and count > 0: count+1.
  - Otherwise: cand=class; count=1.
  - When count reaches LOCK_COUNT: go to LOCKED; wind=cand; locked=1 in the same update.
- LOCKED, on a legal sample:
  - class == wind: stay in LOCKED.
  - Any other class, including NONE: locked=0; wind holds; go to TRACK with cand=class and count=1 (count=0 if NONE).
- Watchdog:
  - Counts Clock cycles since the last sample_en; cleared by every sample_en.
  - In TRACK or LOCKED, on reaching TIMEOUT: timeout=1 for one cycle; state goes to IDLE; locked=0; count=0.
  - Disabled in IDLE (held at 0).
  - If sample_en and expiry fall in the same cycle, the sample wins: it is processed and no timeout is raised.
- Saturation: count and watchdog never wrap. count is capped at LOCK_COUNT; the watchdog stops at TIMEOUT.
- sample_en low: no change apart from the watchdog; lights is ignored.

Decomposition:
- Shared package runway_pkg:
  - light code constants LT_ENDS=101, LT_MID=010, LT_LEFT=100, LT_RIGHT=001
  - wind code enum WIND_CALM, WIND_R2L, WIND_L2R, WIND_HOLD, plus the internal class NONE
  - decoder state enum IDLE, TRACK, LOCKED
- One sub-module, runway_step_classifier: purely combinational; maps (prev, cur) to class and illegal flag.
- Counters and the FSM live in the top module.

Test Plan:
- Reset mid-LOCKED (wind=01): assert Reset between edges -> wind=00 and locked=0 immediately, without waiting for a Clock edge.
- LOCK_COUNT=3; samples 001,010,100,001 -> locked=1 and wind=01 one cycle after the 4th strobe; samples 101,010,101,010 from reset -> wind=00, locked=1.
- Locked at wind=10 (100,010,001,100); then sample 101 -> locked=0, wind stays 10; then 010,101,010 -> wind=00, locked=1 after the 3rd CALM step.
- Locked at 01; sample lights=111 -> pattern_err pulses one cycle, locked=0, wind=01 held; next legal sample enters TRACK.
- TIMEOUT=8, locked; no strobes for 8 cycles -> timeout pulses once, locked=0; strobe landing exactly on the expiry cycle -> no timeout, sample processed.
- Four strobes of 010 -> wind=11 (HOLD), locked=1; strobes spaced 1 cycle vs 20 cycles give identical results.
